// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order completion via the
// CDB, in-order retirement. A mispredicted entry retiring at the head flushes
// every younger entry. Two combinational tag-read ports serve operand lookup.
module rob_param #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_mispred,
  input  logic [TAG_W-1:0]  rd_tag_a,
  input  logic [TAG_W-1:0]  rd_tag_b,
  output logic              rd_ready_a,
  output logic              rd_ready_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic              commit_wr,
  output logic              flush,
  output logic [TAG_W:0]    count
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [DEPTH-1:0]  mispred_q, mispred_d;
  logic [3:0]        func_q [DEPTH];
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  logic              commitValid_q;
  logic [TAG_W-1:0]  commitTag_q;
  logic [REG_W-1:0]  commitRd_q;
  logic [DATA_W-1:0] commitData_q;
  logic              commitWr_q;
  logic              flush_q;

  logic allocFire;
  logic commitFire;
  logic flushFire;
  logic wbFire;
  logic hitA;
  logic hitB;

  assign alloc_ready  = !rst && (count_q != (TAG_W+1)'(DEPTH)) && !flush_q;
  assign alloc_tag    = tail_q;
  assign allocFire    = alloc_valid && alloc_ready;
  assign commitFire   = valid_q[head_q] && ready_q[head_q];
  assign flushFire    = commitFire && mispred_q[head_q];
  assign wbFire       = wb_valid && valid_q[wb_tag];

  assign commit_valid = commitValid_q;
  assign commit_tag   = commitTag_q;
  assign commit_rd    = commitRd_q;
  assign commit_data  = commitData_q;
  assign commit_wr    = commitWr_q;
  assign flush        = flush_q;
  assign count        = count_q;

  // Next-state for pointers, occupancy and per-entry status bits; a flush wipes everything.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    valid_d   = valid_q;
    ready_d   = ready_q;
    mispred_d = mispred_q;
    if (flushFire) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      valid_d   = '0;
      ready_d   = '0;
      mispred_d = '0;
    end else begin
      if (wbFire) begin
        ready_d[wb_tag]   = 1'b1;
        mispred_d[wb_tag] = wb_mispred;
      end
      if (commitFire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (allocFire) begin
        valid_d[tail_q]   = 1'b1;
        ready_d[tail_q]   = 1'b0;
        mispred_d[tail_q] = 1'b0;
        tail_d            = tail_q + 1'b1;
      end
      count_d = count_q + {{TAG_W{1'b0}}, allocFire} - {{TAG_W{1'b0}}, commitFire};
    end
  end

  // Operand lookup: an entry is readable once complete, or when its result is on the CDB now.
  always_comb begin
    hitA       = wb_valid && (wb_tag == rd_tag_a);
    hitB       = wb_valid && (wb_tag == rd_tag_b);
    rd_ready_a = valid_q[rd_tag_a] && (ready_q[rd_tag_a] || hitA);
    rd_ready_b = valid_q[rd_tag_b] && (ready_q[rd_tag_b] || hitB);
    rd_data_a  = '0;
    rd_data_b  = '0;
    if (rd_ready_a) rd_data_a = hitA ? wb_data : data_q[rd_tag_a];
    if (rd_ready_b) rd_data_b = hitB ? wb_data : data_q[rd_tag_b];
  end

  // State register, entry payload writes and the registered retire/flush outputs.
  always_ff @(posedge clk1) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      valid_q       <= '0;
      ready_q       <= '0;
      mispred_q     <= '0;
      commitValid_q <= 1'b0;
      commitTag_q   <= '0;
      commitRd_q    <= '0;
      commitData_q  <= '0;
      commitWr_q    <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      ready_q       <= ready_d;
      mispred_q     <= mispred_d;
      commitValid_q <= commitFire;
      flush_q       <= flushFire;
      if (commitFire) begin
        commitTag_q  <= head_q;
        commitRd_q   <= rd_q[head_q];
        commitData_q <= data_q[head_q];
        commitWr_q   <= !(func_q[head_q] == 4'b0101 || func_q[head_q] == 4'b0110 ||
                          func_q[head_q] == 4'b0111);
      end
      if (allocFire && !flushFire) begin
        func_q[tail_q] <= alloc_func;
        rd_q[tail_q]   <= alloc_rd;
      end
      if (wbFire && !flushFire) begin
        data_q[wb_tag] <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reorder-buffer model.
module tb_rob_param;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  alloc_func;
  logic [3:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [15:0] wb_data;
  logic        wb_mispred;
  logic [2:0]  rd_tag_a;
  logic [2:0]  rd_tag_b;
  logic        rd_ready_a;
  logic        rd_ready_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        commit_valid;
  logic [2:0]  commit_tag;
  logic [3:0]  commit_rd;
  logic [15:0] commit_data;
  logic        commit_wr;
  logic        flush;
  logic [3:0]  count;

  int testsRun = 0;
  int testsFailed = 0;

  rob_param #(.DEPTH(8), .TAG_W(3), .DATA_W(16), .REG_W(4)) dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_mispred(wb_mispred),
    .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
    .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_wr(commit_wr), .flush(flush), .count(count)
  );

  // Free-running clock.
  always #5 clk1 = ~clk1;

  // Reference model: in-flight instructions in program order, oldest first.
  typedef struct {
    logic [3:0]  func;
    logic [3:0]  rd;
    bit          ready;
    bit          mispred;
    logic [15:0] data;
  } entry_t;

  entry_t rob[$];
  int mHead = 0;
  bit mCv = 0;
  int mCtag = 0;
  int mCrd = 0;
  int mCdata = 0;
  bit mCwr = 0;
  bit mFlush = 0;

  typedef struct {
    bit          av;
    logic [3:0]  fn;
    logic [3:0]  rd;
    bit          wv;
    logic [2:0]  wt;
    logic [15:0] wd;
    int          expTag;
    bit          expCv;
    int          expCtag;
    int          expCdata;
    int          expCount;
  } vec_t;

  vec_t vecs[9];

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected read-port result: in flight, and complete or being written back right now.
  function automatic void expRead(input logic [2:0] t, output bit r, output int d);
    int n;
    int idx;
    bit hit;
    n   = rob.size();
    idx = (int'(t) - mHead + 8) % 8;
    hit = wb_valid && (wb_tag == t);
    r   = 0;
    d   = 0;
    if (idx < n) begin
      if (rob[idx].ready || hit) begin
        r = 1;
        d = hit ? int'(wb_data) : int'(rob[idx].data);
      end
    end
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    int n;
    int idx;
    bit acc;
    bit cf;
    bit fl;
    entry_t e;
    n = rob.size();
    if (rst) begin
      rob.delete();
      mHead = 0; mCv = 0; mCtag = 0; mCrd = 0; mCdata = 0; mCwr = 0; mFlush = 0;
      return;
    end
    acc = alloc_valid && (n != 8) && !mFlush;
    cf  = (n > 0) && rob[0].ready;
    fl  = cf && rob[0].mispred;
    mCv = cf;
    if (cf) begin
      mCtag  = mHead;
      mCrd   = int'(rob[0].rd);
      mCdata = int'(rob[0].data);
      mCwr   = !(rob[0].func inside {4'd5, 4'd6, 4'd7});
    end
    mFlush = fl;
    if (fl) begin
      rob.delete();
      mHead = 0;
    end else begin
      if (wb_valid) begin
        idx = (int'(wb_tag) - mHead + 8) % 8;
        if (idx < n) begin
          rob[idx].ready   = 1;
          rob[idx].data    = wb_data;
          rob[idx].mispred = wb_mispred;
        end
      end
      if (cf) begin
        void'(rob.pop_front());
        mHead = (mHead + 1) % 8;
      end
      if (acc) begin
        e.func = alloc_func; e.rd = alloc_rd; e.ready = 0; e.mispred = 0; e.data = '0;
        rob.push_back(e);
      end
    end
  endtask

  // One cycle: check combinational outputs, clock, update model, check registered outputs.
  task automatic applyStimulus();
    bit r;
    int d;
    #1;
    checkOutput("alloc_ready", int'(alloc_ready),
                int'(!rst && rob.size() != 8 && !mFlush));
    checkOutput("alloc_tag", int'(alloc_tag), (mHead + rob.size()) % 8);
    checkOutput("count_pre", int'(count), rob.size());
    expRead(rd_tag_a, r, d);
    checkOutput("rd_ready_a", int'(rd_ready_a), int'(r));
    checkOutput("rd_data_a", int'(rd_data_a), d);
    expRead(rd_tag_b, r, d);
    checkOutput("rd_ready_b", int'(rd_ready_b), int'(r));
    checkOutput("rd_data_b", int'(rd_data_b), d);
    @(posedge clk1);
    modelEdge();
    #1;
    checkOutput("commit_valid", int'(commit_valid), int'(mCv));
    checkOutput("flush", int'(flush), int'(mFlush));
    checkOutput("count", int'(count), rob.size());
    if (mCv) begin
      checkOutput("commit_tag", int'(commit_tag), mCtag);
      checkOutput("commit_rd", int'(commit_rd), mCrd);
      checkOutput("commit_data", int'(commit_data), mCdata);
      checkOutput("commit_wr", int'(commit_wr), int'(mCwr));
    end
    @(negedge clk1);
  endtask

  task automatic idleInputs();
    rst = 0; alloc_valid = 0; alloc_func = '0; alloc_rd = '0;
    wb_valid = 0; wb_tag = '0; wb_data = '0; wb_mispred = 0;
    rd_tag_a = '0; rd_tag_b = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1;
    applyStimulus();
    rst = 0;
  endtask

  task automatic doAlloc(input logic [3:0] fn, input logic [3:0] rd);
    idleInputs();
    alloc_valid = 1; alloc_func = fn; alloc_rd = rd;
    applyStimulus();
    idleInputs();
  endtask

  task automatic doWb(input logic [2:0] t, input logic [15:0] d, input bit m);
    idleInputs();
    wb_valid = 1; wb_tag = t; wb_data = d; wb_mispred = m;
    applyStimulus();
    idleInputs();
  endtask

  initial begin
    int n;
    int expTags[4];
    int seenTags[$];

    // Test 1 as a cycle table: three allocs, out-of-order writebacks, in-order commits.
    vecs[0] = '{1, 4'd0, 4'd1, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 1};
    vecs[1] = '{1, 4'd0, 4'd2, 0, 3'd0, 16'h0000, 1, 0, 0, 0, 2};
    vecs[2] = '{1, 4'd0, 4'd3, 0, 3'd0, 16'h0000, 2, 0, 0, 0, 3};
    vecs[3] = '{0, 4'd0, 4'd0, 1, 3'd2, 16'h0022, 3, 0, 0, 0, 3};
    vecs[4] = '{0, 4'd0, 4'd0, 1, 3'd0, 16'h0010, 3, 0, 0, 0, 3};
    vecs[5] = '{0, 4'd0, 4'd0, 1, 3'd1, 16'h0011, 3, 1, 0, 16'h0010, 2};
    vecs[6] = '{0, 4'd0, 4'd0, 0, 3'd0, 16'h0000, 3, 1, 1, 16'h0011, 1};
    vecs[7] = '{0, 4'd0, 4'd0, 0, 3'd0, 16'h0000, 3, 1, 2, 16'h0022, 0};
    vecs[8] = '{0, 4'd0, 4'd0, 0, 3'd0, 16'h0000, 3, 0, 0, 0, 0};

    idleInputs();
    rst = 1;
    @(posedge clk1);
    #1;
    @(negedge clk1);
    doReset();
    checkOutput("reset_commit_valid", int'(commit_valid), 0);
    checkOutput("reset_flush", int'(flush), 0);
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_commit_tag", int'(commit_tag), 0);
    checkOutput("reset_commit_data", int'(commit_data), 0);
    checkOutput("reset_commit_wr", int'(commit_wr), 0);

    for (int i = 0; i < 9; i++) begin
      idleInputs();
      alloc_valid = vecs[i].av; alloc_func = vecs[i].fn; alloc_rd = vecs[i].rd;
      wb_valid = vecs[i].wv; wb_tag = vecs[i].wt; wb_data = vecs[i].wd;
      #1;
      checkOutput($sformatf("vec%0d_alloc_tag", i), int'(alloc_tag), vecs[i].expTag);
      applyStimulus();
      checkOutput($sformatf("vec%0d_commit_valid", i), int'(commit_valid), int'(vecs[i].expCv));
      if (vecs[i].expCv) begin
        checkOutput($sformatf("vec%0d_commit_tag", i), int'(commit_tag), vecs[i].expCtag);
        checkOutput($sformatf("vec%0d_commit_data", i), int'(commit_data), vecs[i].expCdata);
      end
      checkOutput($sformatf("vec%0d_count", i), int'(count), vecs[i].expCount);
    end

    // Test 2: fill, drop the ninth alloc, then free one slot.
    doReset();
    for (int i = 0; i < 8; i++) doAlloc(4'd0, 4'(i));
    checkOutput("full_alloc_ready", int'(alloc_ready), 0);
    checkOutput("full_count", int'(count), 8);
    doAlloc(4'd0, 4'd9);
    checkOutput("ninth_dropped_count", int'(count), 8);
    doWb(3'd0, 16'h1234, 0);
    checkOutput("full_wb_no_commit", int'(commit_valid), 0);
    applyStimulus();
    checkOutput("full_commit_valid", int'(commit_valid), 1);
    checkOutput("full_commit_tag", int'(commit_tag), 0);
    checkOutput("full_commit_rd", int'(commit_rd), 0);
    checkOutput("full_count_after", int'(count), 7);
    checkOutput("full_alloc_ready_after", int'(alloc_ready), 1);

    // Test 3: wrap the tail 7->0 with head not at zero.
    doReset();
    for (int i = 0; i < 6; i++) doAlloc(4'd0, 4'(i));
    for (int i = 0; i < 6; i++) doWb(3'(i), 16'(i), 0);
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("wrap_empty", int'(count), 0);
    expTags = '{6, 7, 0, 1};
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("wrap_alloc_tag%0d", i), int'(alloc_tag), expTags[i]);
      doAlloc(4'd1, 4'(i + 8));
    end
    for (int i = 0; i < 4; i++) begin
      doWb(3'(expTags[i]), 16'(16'h0100 + i), 0);
      if (commit_valid) seenTags.push_back(int'(commit_tag));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      if (commit_valid) seenTags.push_back(int'(commit_tag));
    end
    checkOutput("wrap_commit_count", seenTags.size(), 4);
    for (int i = 0; i < 4 && i < seenTags.size(); i++)
      checkOutput($sformatf("wrap_commit_order%0d", i), seenTags[i], expTags[i]);

    // Test 4: mispredicted beq retires and flushes the younger sub.
    doReset();
    doAlloc(4'b0000, 4'd1);
    doAlloc(4'b0110, 4'd2);
    doAlloc(4'b0001, 4'd3);
    doWb(3'd1, 16'h0000, 1);
    doWb(3'd0, 16'h0AAA, 0);
    doWb(3'd2, 16'h0CCC, 0);
    checkOutput("misp_add_commit", int'(commit_valid), 1);
    checkOutput("misp_add_tag", int'(commit_tag), 0);
    checkOutput("misp_add_wr", int'(commit_wr), 1);
    checkOutput("misp_add_flush", int'(flush), 0);
    applyStimulus();
    checkOutput("misp_beq_commit", int'(commit_valid), 1);
    checkOutput("misp_beq_tag", int'(commit_tag), 1);
    checkOutput("misp_beq_wr", int'(commit_wr), 0);
    checkOutput("misp_flush", int'(flush), 1);
    checkOutput("misp_count", int'(count), 0);
    checkOutput("misp_alloc_ready_flush", int'(alloc_ready), 0);
    applyStimulus();
    checkOutput("misp_flush_pulse", int'(flush), 0);
    checkOutput("misp_sub_no_commit", int'(commit_valid), 0);
    checkOutput("misp_next_tag", int'(alloc_tag), 0);
    checkOutput("misp_next_ready", int'(alloc_ready), 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("misp_quiet", int'(commit_valid), 0);
    end

    // Test 5: same-cycle writeback bypass on read port a.
    doReset();
    doAlloc(4'd0, 4'd1);
    doAlloc(4'd0, 4'd2);
    idleInputs();
    wb_valid = 1; wb_tag = 3'd1; wb_data = 16'h00AB; rd_tag_a = 3'd1; rd_tag_b = 3'd0;
    #1;
    checkOutput("bypass_ready_a", int'(rd_ready_a), 1);
    checkOutput("bypass_data_a", int'(rd_data_a), 16'h00AB);
    checkOutput("bypass_ready_b", int'(rd_ready_b), 0);
    checkOutput("bypass_data_b", int'(rd_data_b), 0);
    applyStimulus();
    idleInputs();
    rd_tag_a = 3'd1; rd_tag_b = 3'd5;
    #1;
    checkOutput("stored_ready_a", int'(rd_ready_a), 1);
    checkOutput("stored_data_a", int'(rd_data_a), 16'h00AB);
    checkOutput("invalid_ready_b", int'(rd_ready_b), 0);
    applyStimulus();

    // Test 6: reset with five entries pending discards them without commits.
    doReset();
    for (int i = 0; i < 5; i++) doAlloc(4'd0, 4'(i));
    for (int i = 1; i < 5; i++) doWb(3'(i), 16'(i), 0);
    idleInputs();
    rst = 1; wb_valid = 1; wb_tag = 3'd0; wb_data = 16'h5555;
    #1;
    checkOutput("rst_alloc_ready", int'(alloc_ready), 0);
    applyStimulus();
    idleInputs();
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_commit_valid", int'(commit_valid), 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("rst_no_commit", int'(commit_valid), 0);
    end

    // Randomized traffic against the model.
    doReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n = rob.size();
      idleInputs();
      rst         = ($urandom_range(199) == 0);
      alloc_valid = ($urandom_range(2) != 0);
      alloc_func  = 4'($urandom_range(7));
      alloc_rd    = 4'($urandom);
      wb_valid    = ($urandom_range(9) < 6);
      if (n > 0 && $urandom_range(7) != 0)
        wb_tag = 3'((mHead + int'($urandom_range(n - 1))) % 8);
      else
        wb_tag = 3'($urandom);
      wb_data    = 16'($urandom);
      wb_mispred = ($urandom_range(19) == 0);
      rd_tag_a   = 3'($urandom);
      rd_tag_b   = ($urandom_range(1) == 0) ? wb_tag : 3'($urandom);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
